// File: rtl/ysyx_041461_pipe_pkg.sv
// ysyx_041461_pipe_pkg: stage-register state encoding and shared stage payload layout
package ysyx_041461_pipe_pkg;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_FULL  = 2'd2
   } pipe_st_e;

   localparam int unsigned XLEN    = 64;
   localparam int unsigned PC_W    = 64;
   localparam int unsigned INST_W  = 32;
   localparam int unsigned REG_AW  = 5;
   localparam int unsigned CSR_AW  = 12;
   localparam int unsigned CTRL_W  = 16;

   // IF/ID payload: {pc, inst}
   localparam int unsigned IFID_INST_LSB = 0;
   localparam int unsigned IFID_PC_LSB   = IFID_INST_LSB + INST_W;
   localparam int unsigned IFID_W        = IFID_PC_LSB + PC_W;

   // ID/EXE payload: {pc, imm, csr, rs2, rs1, rd, ctrl}
   localparam int unsigned IDEX_CTRL_LSB = 0;
   localparam int unsigned IDEX_RD_LSB   = IDEX_CTRL_LSB + CTRL_W;
   localparam int unsigned IDEX_RS1_LSB  = IDEX_RD_LSB + REG_AW;
   localparam int unsigned IDEX_RS2_LSB  = IDEX_RS1_LSB + REG_AW;
   localparam int unsigned IDEX_CSR_LSB  = IDEX_RS2_LSB + REG_AW;
   localparam int unsigned IDEX_IMM_LSB  = IDEX_CSR_LSB + CSR_AW;
   localparam int unsigned IDEX_PC_LSB   = IDEX_IMM_LSB + XLEN;
   localparam int unsigned IDEX_W        = IDEX_PC_LSB + PC_W;

   // EXE/MEM payload: {pc, result, rd, ctrl}
   localparam int unsigned EXMEM_CTRL_LSB = 0;
   localparam int unsigned EXMEM_RD_LSB   = EXMEM_CTRL_LSB + CTRL_W;
   localparam int unsigned EXMEM_RES_LSB  = EXMEM_RD_LSB + REG_AW;
   localparam int unsigned EXMEM_PC_LSB   = EXMEM_RES_LSB + XLEN;
   localparam int unsigned EXMEM_W        = EXMEM_PC_LSB + PC_W;

   // MEM/WB payload: {wdata, rd, wen}
   localparam int unsigned MEMWB_WEN_LSB   = 0;
   localparam int unsigned MEMWB_RD_LSB    = MEMWB_WEN_LSB + 1;
   localparam int unsigned MEMWB_WDATA_LSB = MEMWB_RD_LSB + REG_AW;
   localparam int unsigned MEMWB_W         = MEMWB_WDATA_LSB + XLEN;

   function automatic logic st_has_entry(input pipe_st_e s);
      return s != ST_EMPTY;
   endfunction

   function automatic logic st_can_accept(input pipe_st_e s);
      return s != ST_FULL;
   endfunction

endpackage

// File: rtl/ysyx_041461_sat_cnt.sv
// ysyx_041461_sat_cnt: saturating event counter, async active-high reset
module ysyx_041461_sat_cnt #(
   parameter int unsigned CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc,
   output logic [CNT_W-1:0] cnt
);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   // count up by one per qualifying cycle, stick at all-ones
   always_comb cnt_d = (inc && !(&cnt_q)) ? cnt_q + CNT_W'(1) : cnt_q;

   // counter register, cleared only by reset
   always_ff @(posedge clk or posedge rst)
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;

   assign cnt = cnt_q;

endmodule

// File: rtl/ysyx_041461_pipe_skid_reg.sv
// ysyx_041461_pipe_skid_reg: valid/ready stage register with 2-entry skid, kill and flush; perf counters under YSYX_041461_PIPE_PERF_EN
module ysyx_041461_pipe_skid_reg
   import ysyx_041461_pipe_pkg::*;
#(
   parameter int unsigned       DATA_W   = 128,
   parameter logic [DATA_W-1:0] RST_DATA = {DATA_W{1'b0}},
   parameter int unsigned       CNT_W    = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              in_kill,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data
`ifdef YSYX_041461_PIPE_PERF_EN
   ,
   output logic [CNT_W-1:0]  stall_cnt,
   output logic [CNT_W-1:0]  kill_cnt
`endif
);

   if (DATA_W < 1 || CNT_W < 1) begin : g_bad_param
      $error("ysyx_041461_pipe_skid_reg: DATA_W and CNT_W must be >= 1");
   end

   pipe_st_e          state_q;
   logic [DATA_W-1:0] main_q, skid_q;
   logic              out_valid_q, in_ready_q;
   logic              acc, cap, deq;

   // a killed beat completes its handshake but is never stored
   assign acc = in_valid & in_ready_q & ~flush;
   assign cap = acc & ~in_kill;
   assign deq = out_valid_q & out_ready;

   // occupancy FSM; handshake outputs are registered alongside the state so
   // in_ready never depends combinationally on out_ready
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state_q     <= ST_EMPTY;
         main_q      <= RST_DATA;
         skid_q      <= RST_DATA;
         out_valid_q <= 1'b0;
         in_ready_q  <= 1'b1;
      end else if (flush) begin
         state_q     <= ST_EMPTY;
         out_valid_q <= 1'b0;
         in_ready_q  <= 1'b1;
      end else begin
         case (state_q)
            ST_EMPTY:
               if (cap) begin
                  state_q     <= ST_ONE;
                  main_q      <= in_data;
                  out_valid_q <= 1'b1;
               end
            ST_ONE:
               if (cap && deq) begin
                  main_q <= in_data;
               end else if (cap) begin
                  state_q    <= ST_FULL;
                  skid_q     <= in_data;
                  in_ready_q <= 1'b0;
               end else if (deq) begin
                  state_q     <= ST_EMPTY;
                  out_valid_q <= 1'b0;
               end
            ST_FULL:
               if (deq) begin
                  state_q    <= ST_ONE;
                  main_q     <= skid_q;
                  in_ready_q <= 1'b1;
               end
            default: begin
               state_q     <= ST_EMPTY;
               out_valid_q <= 1'b0;
               in_ready_q  <= 1'b1;
            end
         endcase
      end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign out_data  = main_q;

`ifdef YSYX_041461_PIPE_PERF_EN
   ysyx_041461_sat_cnt #(.CNT_W(CNT_W)) u_stall_cnt (
      .clk (clk),
      .rst (rst),
      .inc (out_valid_q & ~out_ready),
      .cnt (stall_cnt)
   );

   ysyx_041461_sat_cnt #(.CNT_W(CNT_W)) u_kill_cnt (
      .clk (clk),
      .rst (rst),
      .inc (acc & in_kill),
      .cnt (kill_cnt)
   );
`endif

endmodule

// File: tb/tb_ysyx_041461_pipe_skid_reg.sv
// tb_ysyx_041461_pipe_skid_reg: directed table-driven bench for the skid stage register
module tb_ysyx_041461_pipe_skid_reg;

   localparam int unsigned DW  = 16;
   localparam int unsigned CW  = 4;
   localparam logic [DW-1:0] RD = 16'hA5A5;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          flush = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic          in_kill = 1'b0;
   logic [DW-1:0] in_data = '0;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [DW-1:0] out_data;
`ifdef YSYX_041461_PIPE_PERF_EN
   logic [CW-1:0] stall_cnt, kill_cnt;
`endif

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic          iv, k, fl, ord;
      logic [DW-1:0] d;
      logic          ov, ir;
      logic [DW-1:0] od;
   } vec_t;

   vec_t tbl[$];

   ysyx_041461_pipe_skid_reg #(.DATA_W(DW), .RST_DATA(RD), .CNT_W(CW)) dut (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_kill   (in_kill),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data)
`ifdef YSYX_041461_PIPE_PERF_EN
      ,
      .stall_cnt (stall_cnt),
      .kill_cnt  (kill_cnt)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      {flush, in_valid, in_kill, out_ready} = '0;
      step();
      rst = 1'b0;
      step();
   endtask

   initial begin
      // streaming 0x1..0x8, out_ready=1
      for (int i = 0; i < 8; i++)
         tbl.push_back(vec_t'{1, 0, 0, 1, DW'(i + 1), i > 0, 1, (i > 0) ? DW'(i) : RD});
      tbl.push_back(vec_t'{0, 0, 0, 1, 16'h0, 1, 1, 16'h8});
      tbl.push_back(vec_t'{0, 0, 0, 1, 16'h0, 0, 1, 16'h8});
      // backpressure: A, then B, C while out_ready=0
      tbl.push_back(vec_t'{1, 0, 0, 1, 16'hA, 0, 1, 16'h8});
      tbl.push_back(vec_t'{1, 0, 0, 0, 16'hB, 1, 1, 16'hA});
      tbl.push_back(vec_t'{1, 0, 0, 0, 16'hC, 1, 0, 16'hA});
      tbl.push_back(vec_t'{1, 0, 0, 0, 16'hC, 1, 0, 16'hA});
      tbl.push_back(vec_t'{1, 0, 0, 1, 16'hC, 1, 0, 16'hA});
      tbl.push_back(vec_t'{1, 0, 0, 1, 16'hC, 1, 1, 16'hB});
      tbl.push_back(vec_t'{0, 0, 0, 1, 16'h0, 1, 1, 16'hC});
      tbl.push_back(vec_t'{0, 0, 0, 1, 16'h0, 0, 1, 16'hC});
      // kill: 0x10 squashed, 0x11 passes
      tbl.push_back(vec_t'{1, 1, 0, 1, 16'h10, 0, 1, 16'hC});
      tbl.push_back(vec_t'{1, 0, 0, 1, 16'h11, 0, 1, 16'hC});
      tbl.push_back(vec_t'{0, 0, 0, 1, 16'h0, 1, 1, 16'h11});
      tbl.push_back(vec_t'{0, 0, 0, 1, 16'h0, 0, 1, 16'h11});
      // flush in FULL with 0x22 offered
      tbl.push_back(vec_t'{1, 0, 0, 0, 16'h20, 0, 1, 16'h11});
      tbl.push_back(vec_t'{1, 0, 0, 0, 16'h21, 1, 1, 16'h20});
      tbl.push_back(vec_t'{1, 0, 1, 0, 16'h22, 1, 0, 16'h20});
      tbl.push_back(vec_t'{0, 0, 0, 1, 16'h0, 0, 1, 16'h20});
      tbl.push_back(vec_t'{0, 0, 0, 1, 16'h0, 0, 1, 16'h20});
      // flush in ONE drops an otherwise accepted beat
      tbl.push_back(vec_t'{1, 0, 0, 1, 16'h30, 0, 1, 16'h20});
      tbl.push_back(vec_t'{1, 0, 1, 1, 16'h31, 1, 1, 16'h30});
      tbl.push_back(vec_t'{0, 0, 0, 1, 16'h0, 0, 1, 16'h30});
      tbl.push_back(vec_t'{0, 0, 0, 1, 16'h0, 0, 1, 16'h30});

      do_reset();
      chk("rst_out_valid", out_valid, 0);
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_data", out_data, RD);
`ifdef YSYX_041461_PIPE_PERF_EN
      chk("rst_stall_cnt", stall_cnt, 0);
      chk("rst_kill_cnt", kill_cnt, 0);
`endif

      foreach (tbl[i]) begin
         in_valid  = tbl[i].iv;
         in_kill   = tbl[i].k;
         flush     = tbl[i].fl;
         out_ready = tbl[i].ord;
         in_data   = tbl[i].d;
         chk($sformatf("vec%0d_out_valid", i), out_valid, tbl[i].ov);
         chk($sformatf("vec%0d_in_ready", i), in_ready, tbl[i].ir);
         chk($sformatf("vec%0d_out_data", i), out_data, tbl[i].od);
         step();
      end
      {flush, in_valid, in_kill} = '0;
`ifdef YSYX_041461_PIPE_PERF_EN
      chk("tbl_kill_cnt", kill_cnt, 1);
      chk("tbl_stall_cnt", stall_cnt, 5);
`endif

      // async reset mid-cycle while FULL
      out_ready = 1'b0;
      in_valid = 1'b1;
      in_data = 16'h40;
      step();
      in_data = 16'h41;
      step();
      in_valid = 1'b0;
      chk("full_in_ready", in_ready, 0);
      #3 rst = 1'b1;
      #1;
      chk("arst_out_valid", out_valid, 0);
      chk("arst_in_ready", in_ready, 1);
      chk("arst_out_data", out_data, RD);
`ifdef YSYX_041461_PIPE_PERF_EN
      chk("arst_stall_cnt", stall_cnt, 0);
`endif
      #1 rst = 1'b0;
      step();
      chk("post_arst_out_valid", out_valid, 0);
      chk("post_arst_out_data", out_data, RD);

      // stall saturation: one beat held 20 cycles
      in_valid = 1'b1;
      in_data = 16'h50;
      step();
      in_valid = 1'b0;
      for (int i = 0; i < 20; i++) begin
         chk($sformatf("hold%0d_out_valid", i), out_valid, 1);
         chk($sformatf("hold%0d_out_data", i), out_data, 16'h50);
         step();
      end
`ifdef YSYX_041461_PIPE_PERF_EN
      chk("sat_stall_cnt", stall_cnt, 15);
      chk("sat_kill_cnt", kill_cnt, 0);
`endif
      out_ready = 1'b1;
      step();
      chk("drain_out_valid", out_valid, 0);
      chk("drain_in_ready", in_ready, 1);
`ifdef YSYX_041461_PIPE_PERF_EN
      flush = 1'b1;
      step();
      flush = 1'b0;
      chk("flush_keeps_stall_cnt", stall_cnt, 15);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
